alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Execute-stage front end that drives the 32-bit ALU: decodes RV32I opcode/funct fields into the ALU's 3-bit operation select, steers operands onto the ALU inputs, and captures the ALU result and zero flag into a one-entry output register with valid/ready handshakes on both sides. Sits between the register-read stage and write-back/branch logic. It also flags unsupported encodings and counts issued operations.

## Interface
- XLEN, 32, datapath width; fixed to the ALU width, not to be overridden.
- CNT_W, 16, width of the issued-operation counter.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  stage can accept an operation this cycle.
- opcode  in  7  instruction bits [6:0].
- funct3  in  3  instruction bits [14:12].
- funct7_5  in  1  instruction bit 30.
- rs1_val  in  XLEN  source operand 1.
- rs2_val  in  XLEN  source operand 2.
- imm  in  XLEN  sign-extended immediate.
- alu_a  out  XLEN  to ALU A; always rs1_val.
- alu_b  out  XLEN  to ALU B; imm for OP-IMM, else rs2_val.
- alu_sel  out  3  to ALU sel (combinational decode).
- alu_out  in  XLEN  ALU result.
- alu_zero  in  1  ALU zero flag; meaningful only when alu_sel = 3'b001.
- out_valid  out  1  result register holds a valid operation.
- out_ready  in  1  downstream accepts result.
- result  out  XLEN  registered ALU result.
- illegal  out  1  registered: captured operation was an unsupported encoding.
- op_count  out  CNT_W  accepted legal operations, wrapping.
- br_taken  out  1  registered branch decision (only with BRANCH_RESOLVE_EN).

## Operation
- Decode (combinational, from current inputs):
  - OP (0110011): funct3 000 → funct7_5=0 add 3'b000, =1 sub 3'b001; 111 → and 3'b010; 110 → or 3'b011; 010 → slt 3'b101.
  - OP-IMM (0010011): funct3 000 add, 111 and, 110 or, 010 slt; funct7_5 ignored.
  - BRANCH (1100011): funct3 000 (BEQ) and 001 (BNE) → sub 3'b001, alu_b = rs2_val.
  - Anything else: alu_sel = 3'b111, decode marked illegal.
- Output register FSM, two states: EMPTY (out_valid=0), FULL (out_valid=1).
  - in_ready = !out_valid || out_ready (same-cycle pass-through on drain).
  - Accept = in_valid && in_ready. On accept: result ← alu_out (0 if illegal), illegal ← decode-illegal, state → FULL.
  - FULL with out_ready and no accept → EMPTY. FULL with out_ready and accept → stays FULL, new contents.
  - FULL with !out_ready: all registered outputs held stable; in_ready = 0.
- op_count increments by 1 on each accept of a legal operation; illegal accepts do not count; wraps from 2^CNT_W−1 to 0.
- Operand inputs must be stable only in the accepting cycle.

## Timing
- Latency: accept in cycle N → out_valid, result, illegal visible from cycle N+1.
- Throughput: one operation per cycle while out_ready held high.
- alu_a/alu_b/alu_sel are combinational from inputs; ALU path must close within one cycle.
- Reset (asynchronous, any time, including FULL mid-stall): out_valid=0, result=0, illegal=0, br_taken=0, op_count=0, state EMPTY; held operation discarded. in_ready=1 after reset deassertion.

## Configuration
- BRANCH_RESOLVE_EN defined: on accepting a BRANCH, br_taken ← alu_zero for BEQ, ← !alu_zero for BNE; br_taken ← 0 for non-branch accepts; held with the other registered outputs.
- Not defined: br_taken port absent; BRANCH decodes to sub and result carries rs1−rs2 only.

## Test plan
- Reset: assert rst while FULL with out_ready=0 → out_valid=0, result=0, op_count=0 immediately (no clock edge needed).
- ADD then SUB back-to-back, out_ready=1: rs1=7, rs2=5 → results 12 then 2 on consecutive cycles, op_count=2.
- OP-IMM SLT: rs1=0xFFFFFFFF, imm=1 → alu_b=1, alu_sel=3'b101, result as produced by ALU; stall out_ready=0 three cycles → result held, in_ready=0.
- Illegal: opcode 0110111 → alu_sel=3'b111, illegal=1, result=0, op_count unchanged.
- Branch (BRANCH_RESOLVE_EN): BEQ rs1=rs2=9 → br_taken=1; BNE same operands → br_taken=0; ADD next → br_taken=0.
- Counter wrap with CNT_W=4: 17 legal accepts → op_count=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I execute-stage front end: decodes opcode/funct into the ALU select, steers operands,
// and registers the ALU result behind valid/ready handshakes. Optional macro: BRANCH_RESOLVE_EN.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [2:0]       alu_sel,
  input  logic [XLEN-1:0]  alu_out,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
`ifdef BRANCH_RESOLVE_EN
  ,
  output logic             br_taken
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       dec_sel;
  logic             dec_illegal;
  logic             accept;

  always_comb begin
    dec_sel     = 3'b111;
    dec_illegal = 1'b1;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec_illegal = 1'b0;
        case (funct3)
          // funct7_5 selects subtract only for register-register ops
          3'b000:  dec_sel = (opcode == OPC_OP && funct7_5) ? 3'b001 : 3'b000;
          3'b111:  dec_sel = 3'b010;
          3'b110:  dec_sel = 3'b011;
          3'b010:  dec_sel = 3'b101;
          default: begin
            dec_sel     = 3'b111;
            dec_illegal = 1'b1;
          end
        endcase
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec_sel     = 3'b001;
          dec_illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign alu_a     = rs1_val;
  assign alu_b     = (opcode == OPC_OP_IMM) ? imm : rs2_val;
  assign alu_sel   = dec_sel;
  assign out_valid = (state_q == FULL);
  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign result    = result_q;
  assign illegal   = illegal_q;
  assign op_count  = count_q;

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    if (accept) begin
      state_d   = FULL;
      result_d  = dec_illegal ? '0 : alu_out;
      illegal_d = dec_illegal;
      if (!dec_illegal) count_d = count_q + CNT_W'(1);
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      result_q  <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

`ifdef BRANCH_RESOLVE_EN
  logic br_taken_q, br_taken_d;

  always_comb begin
    br_taken_d = br_taken_q;
    if (accept) begin
      // funct3[0] distinguishes BNE from BEQ
      br_taken_d = (opcode == OPC_BRANCH) && !dec_illegal &&
                   (funct3[0] ? !alu_zero : alu_zero);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) br_taken_q <= 1'b0;
    else     br_taken_q <= br_taken_d;
  end

  assign br_taken = br_taken_q;
`else
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: vector table plus stall, reset and counter-wrap
// sequences, with a behavioural ALU and a result scoreboard.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_val, rs2_val, imm;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        alu_zero;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        illegal;
  logic [3:0]  op_count;
`ifdef BRANCH_RESOLVE_EN
  logic        br_taken;
`endif

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .illegal(illegal), .op_count(op_count)
`ifdef BRANCH_RESOLVE_EN
    , .br_taken(br_taken)
`endif
  );

  // Behavioural ALU; unsupported selects return a marker so zeroing of illegal results is visible
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b101:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_out = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [2:0]  sel;
    logic [31:0] res;
    logic        ill;
    logic        br;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    logic        br;
    logic [3:0]  cnt;
  } exp_t;

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [3:0] exp_cnt;
  bit         acc_pending = 1'b0;
  int         errors = 0;
  int         checks = 0;
  vec_t       tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                              input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] im,
                              input logic [2:0] sel, input logic [31:0] res, input logic ill,
                              input logic br);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2; v.imm = im;
    v.sel = sel; v.res = res; v.ill = ill; v.br = br;
    return v;
  endfunction

  task automatic send(input vec_t r);
    logic [31:0] eb;
    int unsigned n;
    @(negedge clk);
    opcode = r.opc; funct3 = r.f3; funct7_5 = r.f7;
    rs1_val = r.rs1; rs2_val = r.rs2; imm = r.imm; in_valid = 1'b1;
    #1;
    chk("alu_sel", {29'b0, alu_sel}, {29'b0, r.sel});
    chk("alu_a", alu_a, r.rs1);
    eb = (r.opc == OPI) ? r.imm : r.rs2;
    chk("alu_b", alu_b, eb);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
    end else begin
      if (!r.ill) exp_cnt = exp_cnt + 4'd1;
      sb.push_back('{res: r.res, ill: r.ill, br: r.br, cnt: exp_cnt});
      acc_pending = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    if (acc_pending) begin
      acc_pending = 1'b0;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_valid", {31'b0, out_valid}, 32'd1);
        chk("result", result, mon_e.res);
        chk("illegal", {31'b0, illegal}, {31'b0, mon_e.ill});
        chk("op_count", {28'b0, op_count}, {28'b0, mon_e.cnt});
`ifdef BRANCH_RESOLVE_EN
        chk("br_taken", {31'b0, br_taken}, {31'b0, mon_e.br});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(OP,  3'b000, 1'b0, 32'd7,        32'd5,        32'd0,        3'b000, 32'd12,       1'b0, 1'b0);
    tbl[1]  = mk(OP,  3'b000, 1'b1, 32'd7,        32'd5,        32'd0,        3'b001, 32'd2,        1'b0, 1'b0);
    tbl[2]  = mk(OP,  3'b111, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'd0,        3'b010, 32'h0000F000, 1'b0, 1'b0);
    tbl[3]  = mk(OP,  3'b110, 1'b0, 32'h0000F0F0, 32'h00000F0F, 32'd0,        3'b011, 32'h0000FFFF, 1'b0, 1'b0);
    tbl[4]  = mk(OP,  3'b010, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        3'b101, 32'd1,        1'b0, 1'b0);
    tbl[5]  = mk(OP,  3'b010, 1'b0, 32'd5,        32'hFFFFFFFE, 32'd0,        3'b101, 32'd0,        1'b0, 1'b0);
    tbl[6]  = mk(OPI, 3'b000, 1'b0, 32'd100,      32'h999,      32'hFFFFFFFF, 3'b000, 32'd99,       1'b0, 1'b0);
    tbl[7]  = mk(OPI, 3'b000, 1'b1, 32'd10,       32'd77,       32'd3,        3'b000, 32'd13,       1'b0, 1'b0);
    tbl[8]  = mk(OPI, 3'b111, 1'b1, 32'h0000ABCD, 32'd0,        32'h000000FF, 3'b010, 32'h000000CD, 1'b0, 1'b0);
    tbl[9]  = mk(OPI, 3'b110, 1'b0, 32'h00000100, 32'd0,        32'd1,        3'b011, 32'h00000101, 1'b0, 1'b0);
    tbl[10] = mk(OPI, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd0,        32'd1,        3'b101, 32'd1,        1'b0, 1'b0);
    tbl[11] = mk(BR,  3'b000, 1'b0, 32'd9,        32'd9,        32'd0,        3'b001, 32'd0,        1'b0, 1'b1);
    tbl[12] = mk(BR,  3'b001, 1'b0, 32'd9,        32'd9,        32'd0,        3'b001, 32'd0,        1'b0, 1'b0);
    tbl[13] = mk(OP,  3'b000, 1'b0, 32'd1,        32'd2,        32'd0,        3'b000, 32'd3,        1'b0, 1'b0);
    tbl[14] = mk(BR,  3'b000, 1'b0, 32'd9,        32'd4,        32'd0,        3'b001, 32'd5,        1'b0, 1'b0);
    tbl[15] = mk(BR,  3'b001, 1'b0, 32'd9,        32'd4,        32'd0,        3'b001, 32'd5,        1'b0, 1'b1);
    tbl[16] = mk(LUI, 3'b000, 1'b0, 32'd3,        32'd4,        32'd0,        3'b111, 32'd0,        1'b1, 1'b0);
    tbl[17] = mk(OP,  3'b001, 1'b0, 32'd3,        32'd4,        32'd0,        3'b111, 32'd0,        1'b1, 1'b0);
    tbl[18] = mk(BR,  3'b100, 1'b0, 32'd3,        32'd4,        32'd0,        3'b111, 32'd0,        1'b1, 1'b0);
    tbl[19] = mk(OP,  3'b000, 1'b0, 32'hFFFFFFFF, 32'd2,        32'd0,        3'b000, 32'd1,        1'b0, 1'b0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0; rs1_val = '0; rs2_val = '0; imm = '0;
    exp_cnt = '0;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_op_count", {28'b0, op_count}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back table traffic
    for (int i = 0; i < 20; i++) send(tbl[i]);
    idle();
    @(posedge clk); #2;
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_sb_empty", sb.size(), 32'd0);

    // SLTI then stall three cycles with a competing request present
    send(mk(OPI, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd0, 32'd1, 3'b101, 32'd1, 1'b0, 1'b0));
    @(negedge clk);
    out_ready = 1'b0;
    opcode = OP; funct3 = 3'b000; funct7_5 = 1'b0; rs1_val = 32'd1; rs2_val = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_result", result, 32'd1);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_op_count", {28'b0, op_count}, {28'b0, exp_cnt});
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    chk("stall_drain", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset while FULL and stalled
    send(mk(BR, 3'b001, 1'b0, 32'd9, 32'd4, 32'd0, 3'b001, 32'd5, 1'b0, 1'b1));
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_op_count", {28'b0, op_count}, 32'd0);
    chk("arst_illegal", {31'b0, illegal}, 32'd0);
`ifdef BRANCH_RESOLVE_EN
    chk("arst_br_taken", {31'b0, br_taken}, 32'd0);
`endif
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // 17 legal accepts on a 4-bit counter
    for (int i = 0; i < 17; i++)
      send(mk(OP, 3'b000, 1'b0, i, 32'd1, 32'd0, 3'b000, i + 1, 1'b0, 1'b0));
    idle();
    @(posedge clk); #2;
    chk("wrap_op_count", {28'b0, op_count}, 32'd1);
    chk("final_sb_empty", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
